// File: rtl/simple_loop_arb_pkg.sv
// Shared types and constants for the simple_loop round-robin job arbiter.
package simple_loop_arb_pkg;

    localparam int DATA_W = 10;
    localparam logic [DATA_W-1:0] LOOP_BOUND = 10'd950;
    localparam int PERF_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/simple_loop_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, wrapping modulo NUM_REQ.
module simple_loop_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] vld,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    int              sum;
    logic [ID_W-1:0] idx;

    // Walk the requesters starting at ptr and keep the first valid one found.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (!any && vld[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_loop_arbiter.sv
// Round-robin scheduler sharing one simple_loop kernel among NUM_REQ requesters.
// One job in flight at a time: IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
// Optional performance counters are enabled by defining SIMPLE_LOOP_ARB_PERF_EN;
// without it the perf ports read 0 and no counter registers exist.
module simple_loop_arbiter
    import simple_loop_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*DATA_W-1:0] req_n,
    input  logic [NUM_REQ-1:0]        req_n_vld,
    output logic [NUM_REQ-1:0]        req_n_rdy,
    output logic [DATA_W-1:0]         req_result,
    output logic [NUM_REQ-1:0]        req_result_vld,
    input  logic [NUM_REQ-1:0]        req_result_rdy,
    output logic [DATA_W-1:0]         kern_n,
    output logic                      kern_n_vld,
    input  logic                      kern_n_rdy,
    input  logic [DATA_W-1:0]         kern_result,
    input  logic                      kern_result_vld,
    output logic                      kern_result_rdy,
    output logic                      busy,
    output logic [ID_W-1:0]           cur_id,
    output logic [PERF_W-1:0]         perf_jobs,
    output logic [PERF_W-1:0]         perf_last_lat
);

    arb_state_t           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      cur_id_q;
    logic [DATA_W-1:0]    n_reg;
    logic [DATA_W-1:0]    res_reg;
    logic                 kern_n_vld_q;
    logic                 kern_result_rdy_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   req_result_vld_q;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;
    logic                 grant_fire;
    logic                 return_fire;

    simple_loop_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .vld    (req_n_vld),
        .ptr    (rr_ptr),
        .gnt    (pick_gnt),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign grant_fire  = (state == IDLE) && pick_any;
    assign return_fire = (state == RETURN) && req_result_rdy[cur_id_q];

    // Ready is offered only in IDLE; gating with rst_n keeps it low while reset is held.
    assign req_n_rdy = ((state == IDLE) && rst_n) ? pick_gnt : '0;

    assign kern_n          = n_reg;
    assign kern_n_vld      = kern_n_vld_q;
    assign kern_result_rdy = kern_result_rdy_q;
    assign req_result      = res_reg;
    assign req_result_vld  = req_result_vld_q;
    assign busy            = busy_q;
    assign cur_id          = cur_id_q;

    // Job FSM with its handshake outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            cur_id_q          <= '0;
            n_reg             <= '0;
            res_reg           <= '0;
            kern_n_vld_q      <= 1'b0;
            kern_result_rdy_q <= 1'b0;
            req_result_vld_q  <= '0;
            busy_q            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        n_reg        <= req_n[pick_id*DATA_W +: DATA_W];
                        cur_id_q     <= pick_id;
                        kern_n_vld_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (kern_n_rdy) begin
                        kern_n_vld_q      <= 1'b0;
                        kern_result_rdy_q <= 1'b1;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (kern_result_vld) begin
                        res_reg                    <= kern_result;
                        kern_result_rdy_q          <= 1'b0;
                        req_result_vld_q[cur_id_q] <= 1'b1;
                        state                      <= RETURN;
                    end
                end
                RETURN: begin
                    if (req_result_rdy[cur_id_q]) begin
                        req_result_vld_q <= '0;
                        busy_q           <= 1'b0;
                        rr_ptr           <= (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
                        state            <= IDLE;
                    end
                end
                default: begin
                    kern_n_vld_q      <= 1'b0;
                    kern_result_rdy_q <= 1'b0;
                    req_result_vld_q  <= '0;
                    busy_q            <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

`ifdef SIMPLE_LOOP_ARB_PERF_EN
    logic [PERF_W-1:0] jobs_q;
    logic [PERF_W-1:0] lat_cnt;
    logic [PERF_W-1:0] last_lat_q;

    // Saturating job and latency counters; latency includes the RETURN cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jobs_q     <= '0;
            lat_cnt    <= '0;
            last_lat_q <= '0;
        end else begin
            if (grant_fire) begin
                lat_cnt <= '0;
            end else if (busy_q && (lat_cnt != '1)) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (return_fire) begin
                if (jobs_q != '1) begin
                    jobs_q <= jobs_q + 1'b1;
                end
                last_lat_q <= (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;
            end
        end
    end

    assign perf_jobs     = jobs_q;
    assign perf_last_lat = last_lat_q;
`else
    assign perf_jobs     = '0;
    assign perf_last_lat = '0;
`endif

endmodule

// File: tb/tb_simple_loop_arbiter.sv
// Self-checking bench for simple_loop_arbiter: a job-lifecycle reference model
// tracks each request from grant to result return, a small kernel model
// answers with max(n, LOOP_BOUND), and randomized traffic exercises fairness,
// backpressure and reset.
module tb_simple_loop_arbiter;
    import simple_loop_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

`ifdef SIMPLE_LOOP_ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ*DATA_W-1:0] req_n;
    logic [NUM_REQ-1:0]        req_n_vld;
    logic [NUM_REQ-1:0]        req_n_rdy;
    logic [DATA_W-1:0]         req_result;
    logic [NUM_REQ-1:0]        req_result_vld;
    logic [NUM_REQ-1:0]        req_result_rdy;
    logic [DATA_W-1:0]         kern_n;
    logic                      kern_n_vld;
    logic                      kern_n_rdy;
    logic [DATA_W-1:0]         kern_result;
    logic                      kern_result_vld;
    logic                      kern_result_rdy;
    logic                      busy;
    logic [ID_W-1:0]           cur_id;
    logic [PERF_W-1:0]         perf_jobs;
    logic [PERF_W-1:0]         perf_last_lat;

    simple_loop_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_n           (req_n),
        .req_n_vld       (req_n_vld),
        .req_n_rdy       (req_n_rdy),
        .req_result      (req_result),
        .req_result_vld  (req_result_vld),
        .req_result_rdy  (req_result_rdy),
        .kern_n          (kern_n),
        .kern_n_vld      (kern_n_vld),
        .kern_n_rdy      (kern_n_rdy),
        .kern_result     (kern_result),
        .kern_result_vld (kern_result_vld),
        .kern_result_rdy (kern_result_rdy),
        .busy            (busy),
        .cur_id          (cur_id),
        .perf_jobs       (perf_jobs),
        .perf_last_lat   (perf_last_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // requester / kernel environment state
    logic [NUM_REQ-1:0] pend;
    logic [DATA_W-1:0]  pend_n [NUM_REQ];
    int                 req_mode;
    bit                 kn_rand, rr_rand, k_rand_lat, garbage_en;
    int                 kn_block, rr_block, k_lat;
    bit                 kbusy;
    int                 kwait;
    logic [DATA_W-1:0]  kres;

    // handshakes seen before the coming edge
    logic [NUM_REQ-1:0] f_op;
    bit                 f_kn, f_kr;
    logic [DATA_W-1:0]  f_kn_val;

    // reference model of the job in flight
    bit                 m_busy, m_issued, m_got;
    int                 m_owner, m_rr, m_jobs, m_last_lat;
    logic [DATA_W-1:0]  m_n;
    int                 ecount, t_start, done_cnt;
    int                 grant_log[$];
    int                 res_log[$];

    function automatic int ref_kernel(input int n);
        return (n > int'(LOOP_BOUND)) ? n : int'(LOOP_BOUND);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_req_n_rdy"},       32'(req_n_rdy),       32'd0);
        checkOutput({pfx, "_req_result"},      32'(req_result),      32'd0);
        checkOutput({pfx, "_req_result_vld"},  32'(req_result_vld),  32'd0);
        checkOutput({pfx, "_kern_n"},          32'(kern_n),          32'd0);
        checkOutput({pfx, "_kern_n_vld"},      32'(kern_n_vld),      32'd0);
        checkOutput({pfx, "_kern_result_rdy"}, 32'(kern_result_rdy), 32'd0);
        checkOutput({pfx, "_busy"},            32'(busy),            32'd0);
        checkOutput({pfx, "_cur_id"},          32'(cur_id),          32'd0);
        checkOutput({pfx, "_perf_jobs"},       32'(perf_jobs),       32'd0);
        checkOutput({pfx, "_perf_last_lat"},   32'(perf_last_lat),   32'd0);
    endtask

    task automatic resetModel();
        m_busy = 0; m_issued = 0; m_got = 0;
        m_owner = 0; m_rr = 0; m_jobs = 0; m_last_lat = 0;
        pend = '0; kbusy = 0; kwait = 0;
        kern_result_vld = 1'b0; kn_block = 0; rr_block = 0;
        f_op = '0; f_kn = 0; f_kr = 0;
        req_n_vld = '0;
    endtask

    // Compare DUT outputs against the job model, then advance the model by the coming edge.
    task automatic monitorStep();
        int g;
        logic [NUM_REQ-1:0] exp_rdy, exp_rvld;
        ecount++;
        f_op     = req_n_vld & req_n_rdy;
        f_kn     = kern_n_vld && kern_n_rdy;
        f_kr     = kern_result_vld && kern_result_rdy;
        f_kn_val = kern_n;
        if (!rst_n) return;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_rr + k) % NUM_REQ;
                if (g < 0 && req_n_vld[i]) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rvld = '0;
        if (m_got) exp_rvld[m_owner] = 1'b1;
        checkOutput("req_n_rdy",       32'(req_n_rdy),       32'(exp_rdy));
        checkOutput("busy",            32'(busy),            32'(m_busy));
        checkOutput("cur_id",          32'(cur_id),          32'(m_owner));
        checkOutput("kern_n_vld",      32'(kern_n_vld),      32'(m_busy && !m_issued));
        checkOutput("kern_result_rdy", 32'(kern_result_rdy), 32'(m_issued && !m_got));
        checkOutput("req_result_vld",  32'(req_result_vld),  32'(exp_rvld));
        if (m_busy && !m_issued) checkOutput("kern_n", 32'(kern_n), 32'(m_n));
        if (m_got) checkOutput("req_result", 32'(req_result), 32'(ref_kernel(int'(m_n))));
        checkOutput("perf_jobs",     32'(perf_jobs),     PERF_ON ? 32'(m_jobs) : 32'd0);
        checkOutput("perf_last_lat", 32'(perf_last_lat), PERF_ON ? 32'(m_last_lat) : 32'd0);
        if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1; m_issued = 0; m_got = 0;
                m_owner = g; m_n = req_n[g*DATA_W +: DATA_W];
                t_start = ecount;
                grant_log.push_back(g);
            end
        end else if (!m_issued) begin
            if (kern_n_rdy) m_issued = 1;
        end else if (!m_got) begin
            if (kern_result_vld) m_got = 1;
        end else if (req_result_rdy[m_owner]) begin
            m_busy = 0; m_issued = 0; m_got = 0;
            m_rr = (m_owner + 1) % NUM_REQ;
            if (m_jobs < 65535) m_jobs++;
            m_last_lat = ecount - t_start;
            res_log.push_back(int'(req_result));
            done_cnt++;
        end
    endtask

    task automatic driveReqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i]) begin
                if (req_mode == 1 && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    pend_n[i] = 10'($urandom_range(1023));
                end else if (req_mode == 2) begin
                    pend[i] = 1'b1;
                    pend_n[i] = 10'(i);
                end
            end
            req_n[i*DATA_W +: DATA_W] = pend_n[i];
        end
        req_n_vld = pend;
    endtask

    // Requesters, kernel and result consumers react to the handshakes of the last edge.
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) if (f_op[i]) pend[i] = 1'b0;
        driveReqs();
        if (f_kn) begin
            kbusy = 1;
            kern_result_vld = 1'b0;
            kwait = k_rand_lat ? int'($urandom_range(0, 6)) : k_lat;
            kres  = 10'(ref_kernel(int'(f_kn_val)));
        end
        if (f_kr && kbusy) begin
            kbusy = 0;
            kern_result_vld = 1'b0;
        end
        if (kbusy) begin
            if (!kern_result_vld) begin
                if (kwait <= 1) begin
                    kern_result_vld = 1'b1;
                    kern_result = kres;
                end else begin
                    kwait--;
                end
            end
        end else begin
            kern_result_vld = garbage_en ? 1'($urandom_range(1)) : 1'b0;
            kern_result = 10'($urandom_range(1023));
        end
        if (kern_n_vld && kn_block > 0) begin
            kn_block--;
            kern_n_rdy = 1'b0;
        end else begin
            kern_n_rdy = kn_rand ? 1'($urandom_range(1)) : 1'b1;
        end
        if (req_result_vld != '0 && rr_block > 0) begin
            rr_block--;
            req_result_rdy = ~req_result_vld;
        end else begin
            req_result_rdy = rr_rand ? NUM_REQ'($urandom) : '1;
        end
        f_op = '0; f_kn = 0; f_kr = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitorStep();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic runUntilJobs(input int target, input int budget);
        int c;
        c = 0;
        while (done_cnt < target && c < budget) begin
            cycle();
            c++;
        end
        if (done_cnt < target) checkOutput("jobs_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic runUntilIdle(input int budget);
        int c;
        c = 0;
        while ((pend != '0 || m_busy) && c < budget) begin
            cycle();
            c++;
        end
        if (pend != '0 || m_busy) checkOutput("drain_timeout", 32'(pend), 32'd0);
    endtask

    initial begin
        int exp_order[5];
        int exp_bp[2];
        int c;
        exp_order = '{0, 1, 2, 3, 0};
        exp_bp    = '{1, 3};
        rst_n = 1'b0;
        req_n = '0; req_n_vld = '0; req_result_rdy = '0;
        kern_n_rdy = 1'b0; kern_result = '0; kern_result_vld = 1'b0;
        req_mode = 0; kn_rand = 0; rr_rand = 0; k_rand_lat = 0; garbage_en = 0;
        k_lat = 1; ecount = 0; done_cnt = 0; t_start = 0;
        for (int i = 0; i < NUM_REQ; i++) pend_n[i] = '0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkReset("rst");
        rst_n = 1'b1;

        // fairness: everyone requesting, expect 0,1,2,3,0
        grant_log.delete();
        req_mode = 2;
        driveReqs();
        runUntilJobs(done_cnt + 5, 100);
        req_mode = 0;
        runUntilIdle(100);
        checkOutput("fair_count", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            checkOutput("fair_order", 32'(grant_log[k]), 32'(exp_order[k]));

        // single job from requester 0
        pend[0] = 1'b1; pend_n[0] = 10'd5;
        driveReqs();
        runUntilJobs(done_cnt + 1, 40);
        checkOutput("single_owner", 32'(grant_log[$]), 32'd0);
        checkOutput("single_result", 32'(res_log[$]), 32'd950);

        // operand above the bound passes through
        k_lat = 3;
        pend[2] = 1'b1; pend_n[2] = 10'd1000;
        driveReqs();
        runUntilJobs(done_cnt + 1, 40);
        checkOutput("pass_owner", 32'(grant_log[$]), 32'd2);
        checkOutput("pass_result", 32'(res_log[$]), 32'd1000);

        // backpressure on both kernel operand and result, with a competing requester
        grant_log.delete();
        k_lat = 1; kn_block = 7; rr_block = 5;
        pend[1] = 1'b1; pend_n[1] = 10'd600;
        driveReqs();
        c = 0;
        while (!m_busy && c < 20) begin cycle(); c++; end
        checkOutput("bp_granted", 32'(m_busy), 32'd1);
        pend[3] = 1'b1; pend_n[3] = 10'd999;
        driveReqs();
        runUntilIdle(100);
        checkOutput("bp_count", 32'(grant_log.size()), 32'd2);
        for (int k = 0; k < 2 && k < grant_log.size(); k++)
            checkOutput("bp_order", 32'(grant_log[k]), 32'(exp_bp[k]));

        // reset while the job waits on the kernel
        k_lat = 20;
        pend[0] = 1'b1; pend_n[0] = 10'd100;
        driveReqs();
        c = 0;
        while (!(m_issued && !m_got) && c < 20) begin cycle(); c++; end
        checkOutput("wait_reached", 32'(m_issued && !m_got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("midrst");
        resetModel();
        cycle();
        cycle();
        rst_n = 1'b1;

        // fresh job after reset, also used for the perf counters
        k_lat = 10;
        pend[3] = 1'b1; pend_n[3] = 10'd960;
        driveReqs();
        runUntilJobs(done_cnt + 1, 60);
        checkOutput("post_owner", 32'(grant_log[$]), 32'd3);
        checkOutput("post_result", 32'(res_log[$]), 32'd960);
        checkOutput("perf_jobs_one", 32'(perf_jobs), PERF_ON ? 32'd1 : 32'd0);
        checkOutput("perf_lat_12", 32'(perf_last_lat), PERF_ON ? 32'd12 : 32'd0);

        // randomized traffic
        req_mode = 1; kn_rand = 1; rr_rand = 1; k_rand_lat = 1; garbage_en = 1;
        runUntilJobs(done_cnt + 150, 6000);
        req_mode = 0; kn_rand = 0; rr_rand = 0; garbage_en = 0;
        runUntilIdle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_loop_arbiter.md
# simple_loop_arbiter

Round-robin job scheduler that shares one `simple_loop` kernel among `NUM_REQ` requesters. Each requester submits a 10-bit `n` over a valid/ready channel. The block issues exactly one job at a time to the kernel's `n` channel, waits for the kernel's result, and returns the result on the requester's own result channel. It sits between the requester fabric and a single kernel instance and owns all flow control to that kernel.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: requester index width; derived, not overridden.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_n`  in  NUM_REQ*10  packed job operands; requester i occupies bits [10i+9:10i].
- `req_n_vld`  in  NUM_REQ  per-requester operand valid.
- `req_n_rdy`  out  NUM_REQ  per-requester operand ready; at most one bit set.
- `req_result`  out  10  shared result bus, meaningful when any `req_result_vld` bit is set.
- `req_result_vld`  out  NUM_REQ  one-hot result valid, targeted at the owning requester.
- `req_result_rdy`  in  NUM_REQ  per-requester result ready.
- `kern_n`  out  10  operand to the kernel.
- `kern_n_vld`  out  1  operand valid to the kernel.
- `kern_n_rdy`  in  1  kernel operand ready.
- `kern_result`  in  10  kernel result.
- `kern_result_vld`  in  1  kernel result valid.
- `kern_result_rdy`  out  1  ready to the kernel.
- `busy`  out  1  high in every state except IDLE.
- `cur_id`  out  ID_W  index of the job owner; holds its last value while IDLE.
- `perf_jobs`  out  16  completed-job count (see Configuration).
- `perf_last_lat`  out  16  latency of the last completed job (see Configuration).

## Operation
FSM states: IDLE, ISSUE, WAIT, RETURN. Reset state is IDLE.

- **IDLE**
  - Grant = first i with `req_n_vld[i]`, searched from `rr_ptr` upward, modulo NUM_REQ.
  - `req_n_rdy[grant]` is driven combinationally in the same cycle.
  - On the handshake: capture `req_n[grant]` into `n_reg` and grant into `cur_id`, then go to ISSUE.
- **ISSUE**
  - `kern_n_vld`=1 and `kern_n`=`n_reg`.
  - On `kern_n_rdy`, go to WAIT.
- **WAIT**
  - `kern_result_rdy`=1.
  - On `kern_result_vld`, capture `kern_result` into `res_reg` and go to RETURN.
- **RETURN**
  - `req_result_vld[cur_id]`=1 and `req_result`=`res_reg`.
  - On `req_result_rdy[cur_id]`: set `rr_ptr` = (`cur_id`+1) mod NUM_REQ and go to IDLE.

Rules:
- Only one job is in flight at a time. `req_n_rdy` is all-zero outside IDLE.
- `kern_result_vld` outside WAIT is ignored; `kern_result_rdy` stays 0, so the kernel stalls.
- Every `req_result_vld` bit other than `cur_id` stays 0. A `req_result_rdy` from any other requester has no effect.
- `rr_ptr` wraps from NUM_REQ-1 to 0.
- Operands pass through unmodified. The kernel returns max(n, 950); the arbiter does no arithmetic on data.
- Asynchronous reset at any point:
  - Returns to IDLE and clears `rr_ptr`, `cur_id`, `n_reg`, `res_reg` and the perf counters.
  - An in-flight job is dropped.
  - The kernel must be reset together with the arbiter.

## Timing
- Reset values: all `*_rdy` and `*_vld` outputs 0, `req_result`=0, `kern_n`=0, `busy`=0, `cur_id`=0, `perf_*`=0.
- Handshake rule: a transfer occurs on a rising edge where valid and ready are both high. Valid is held until the transfer and never depends combinationally on the same channel's ready.
- Operand accepted at edge T → `kern_n_vld` high from T+1.
- Kernel result accepted at edge R → `req_result_vld` high from R+1.
- RETURN handshake at edge E → IDLE at E+1; a new grant can complete at E+1. Minimum spacing between successive `req_n_rdy` handshakes is 4 cycles.
- `kern_n_vld`, `kern_result_rdy`, `req_result_vld`, `req_result` and `busy` decode from registered state only. `req_n_rdy` is the only combinational output path (`req_n_vld` → `req_n_rdy`).

## Configuration
Macro `SIMPLE_LOOP_ARB_PERF_EN`.

Defined:
- `perf_jobs` increments, saturating at 16'hFFFF, on each RETURN handshake.
- A 16-bit cycle counter, saturating, clears on the ISSUE entry edge and counts every cycle through ISSUE, WAIT and RETURN.
- `perf_last_lat` is loaded with that counter's value plus 1 on the RETURN handshake.

Not defined:
- Both ports remain present and are tied to 0.
- No perf registers are synthesized.

## Structure
- Package `simple_loop_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RETURN);
  - `DATA_W`=10;
  - `LOOP_BOUND`=10'd950, for bench reference models;
  - `PERF_W`=16.
- One sub-module, `simple_loop_rr_pick`:
  - parameter `NUM_REQ`;
  - inputs `vld` and `ptr`;
  - outputs one-hot `gnt`, binary `gnt_id` and `any`;
  - purely combinational.

## Test plan
- Single job: requester 0 sends n=5 → `kern_n`=5 one cycle after the handshake; model kernel returns 950 → `req_result_vld`=4'b0001, `req_result`=950; `busy` falls the cycle after the result handshake.
- Pass-through: requester 2 sends n=1000 → `req_result`=1000 on `req_result_vld[2]`; `cur_id`=2 throughout.
- Fairness: all four `req_n_vld` held high with n=i → grant order 0,1,2,3,0; the wrap from `rr_ptr`=3 to 0 is checked.
- Backpressure: `kern_n_rdy` low for 7 cycles, then requester-1 `req_result_rdy` low for 5 cycles → `kern_n` and `req_result` hold stable and no second `req_n_rdy` occurs.
- Reset mid-WAIT: deassert `rst_n` while a job is in WAIT → all outputs reach their reset values immediately; after release, a new job from requester 3 completes normally.
- With `SIMPLE_LOOP_ARB_PERF_EN`: kernel result returned 10 cycles after `kern_n` handshake, result ready immediate → `perf_jobs`=1 and `perf_last_lat` matches the documented count; without the macro, both read 0.
